// File: rtl/ysyx_22050243_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package ysyx_22050243_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } trap_state_e;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_ECALL = 2'b01;
  localparam logic [1:0] EXC_TIMER = 2'b10;

  localparam int MSTATUS_MIE = 3;
  localparam int MIE_MTIE    = 7;

  // At most one field is ever set: the arbiter resolves priority.
  typedef struct packed {
    logic ecall;
    logic mret;
    logic irq;
  } trap_take_t;

  function automatic logic take_any(input trap_take_t t);
    return t.ecall | t.mret | t.irq;
  endfunction

endpackage

// File: rtl/ysyx_22050243_trap_ctrl_if.sv
// Pipeline/CSR/IF-facing signal bundle of the trap controller.
interface ysyx_22050243_trap_ctrl_if #(
  parameter int DBUS_DATA_WIDTH = 64
);
  logic                       wb_valid;
  logic                       wb_is_ecall;
  logic                       wb_is_mret;
  logic                       timer_irq;
  logic                       mem_busy;
  logic [DBUS_DATA_WIDTH-1:0] mstatus;
  logic [DBUS_DATA_WIDTH-1:0] mie;
  logic [DBUS_DATA_WIDTH-1:0] pc_mtvec;
  logic [DBUS_DATA_WIDTH-1:0] pc_mepc;
  logic                       redirect_ready;
  logic [1:0]                 excep_csr_update;
  logic                       mret_csr_update;
  logic                       wb_kill;
  logic                       flush;
  logic                       redirect_valid;
  logic [DBUS_DATA_WIDTH-1:0] redirect_pc;

  modport master (
    output wb_valid, wb_is_ecall, wb_is_mret, timer_irq, mem_busy,
           mstatus, mie, pc_mtvec, pc_mepc, redirect_ready,
    input  excep_csr_update, mret_csr_update, wb_kill, flush,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  wb_valid, wb_is_ecall, wb_is_mret, timer_irq, mem_busy,
           mstatus, mie, pc_mtvec, pc_mepc, redirect_ready,
    output excep_csr_update, mret_csr_update, wb_kill, flush,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_22050243_trap_arb.sv
// Combinational event arbiter: ECALL > MRET > enabled timer interrupt.
module ysyx_22050243_trap_arb
  import ysyx_22050243_pkg::*;
(
  input  logic       en_i,
  input  logic       wb_valid_i,
  input  logic       wb_is_ecall_i,
  input  logic       wb_is_mret_i,
  input  logic       timer_irq_i,
  input  logic       irq_enabled_i,
  input  logic       mem_busy_i,
  output trap_take_t take_o
);

  logic ecall_req;
  logic mret_req;
  logic irq_req;

  assign ecall_req = en_i & wb_valid_i & wb_is_ecall_i;
  assign mret_req  = en_i & wb_valid_i & wb_is_mret_i;
  // An outstanding bus access defers the interrupt; the level keeps it pending.
  assign irq_req   = en_i & wb_valid_i & timer_irq_i & irq_enabled_i & ~mem_busy_i;

  assign take_o.ecall = ecall_req;
  assign take_o.mret  = mret_req & ~ecall_req;
  assign take_o.irq   = irq_req & ~ecall_req & ~mret_req;

endmodule

// File: rtl/ysyx_22050243_trap_ctrl.sv
// Machine-mode trap controller: takes one trap/MRET event, pulses the CSR
// update, flushes the pipe and holds a fetch redirect until IF accepts it.
module ysyx_22050243_trap_ctrl
  import ysyx_22050243_pkg::*;
#(
  parameter int DBUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_22050243_trap_ctrl_if.slave  bus
);

  trap_state_e                state_q, state_d;
  logic [DBUS_DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  trap_take_t                 take;

  logic [1:0] excep_o;
  logic       mret_o;
  logic       kill_o;
  logic       flush_o;
  logic       rvalid_o;

  ysyx_22050243_trap_arb u_arb (
    .en_i          (state_q == ST_IDLE),
    .wb_valid_i    (bus.wb_valid),
    .wb_is_ecall_i (bus.wb_is_ecall),
    .wb_is_mret_i  (bus.wb_is_mret),
    .timer_irq_i   (bus.timer_irq),
    .irq_enabled_i (bus.mstatus[MSTATUS_MIE] & bus.mie[MIE_MTIE]),
    .mem_busy_i    (bus.mem_busy),
    .take_o        (take)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (take_any(take)) begin
          state_d       = ST_REDIRECT;
          redirect_pc_d = take.mret ? bus.pc_mepc
                                    : {bus.pc_mtvec[DBUS_DATA_WIDTH-1:2], 2'b00};
        end
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Held reset masks even the same-cycle pulses.
  always_comb begin
    excep_o  = EXC_NONE;
    mret_o   = 1'b0;
    kill_o   = 1'b0;
    flush_o  = 1'b0;
    rvalid_o = 1'b0;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          excep_o = take.ecall ? EXC_ECALL : (take.irq ? EXC_TIMER : EXC_NONE);
          mret_o  = take.mret;
          kill_o  = take.irq;
          flush_o = take_any(take);
        end
        ST_REDIRECT: begin
          rvalid_o = 1'b1;
          flush_o  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.excep_csr_update = excep_o;
  assign bus.mret_csr_update  = mret_o;
  assign bus.wb_kill          = kill_o;
  assign bus.flush            = flush_o;
  assign bus.redirect_valid   = rvalid_o;
  assign bus.redirect_pc      = rst ? redirect_pc_q : '0;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.mstatus, bus.mie, bus.pc_mtvec[1:0]};

endmodule

// File: tb/tb_ysyx_22050243_trap_ctrl.sv
// Randomised + directed bench for the trap controller against a rule-level model.
module tb_ysyx_22050243_trap_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22050243_trap_ctrl_if #(.DBUS_DATA_WIDTH(64)) bus ();

  ysyx_22050243_trap_ctrl #(.DBUS_DATA_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Model: "a redirect is pending" plus the PC it offers.
  bit          m_pending = 1'b0;
  logic [63:0] m_pc = 64'h0;
  bit          nx_pending;
  logic [63:0] nx_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    bus.wb_valid       = 1'b0;
    bus.wb_is_ecall    = 1'b0;
    bus.wb_is_mret     = 1'b0;
    bus.timer_irq      = 1'b0;
    bus.mem_busy       = 1'b0;
    bus.redirect_ready = 1'b0;
  endtask

  // Compare every output against the rule-level expectation for this cycle.
  task automatic eval();
    bit ec, mr, iq, any;
    logic [1:0] ex;
    #1;
    ec = 0; mr = 0; iq = 0;
    if (rst && !m_pending && bus.wb_valid) begin
      if (bus.wb_is_ecall) ec = 1;
      else if (bus.wb_is_mret) mr = 1;
      else if (bus.timer_irq && bus.mstatus[3] && bus.mie[7] && !bus.mem_busy) iq = 1;
    end
    any = ec | mr | iq;
    ex  = ec ? 2'd1 : (iq ? 2'd2 : 2'd0);
    chk("excep",  {62'd0, bus.excep_csr_update}, {62'd0, ex});
    chk("mret",   {63'd0, bus.mret_csr_update},  {63'd0, mr});
    chk("wbkill", {63'd0, bus.wb_kill},          {63'd0, iq});
    chk("flush",  {63'd0, bus.flush},            {63'd0, rst && (m_pending || any)});
    chk("rvalid", {63'd0, bus.redirect_valid},   {63'd0, rst && m_pending});
    chk("rpc",    bus.redirect_pc,               rst ? m_pc : 64'h0);
    if (!rst) begin
      nx_pending = 0; nx_pc = 64'h0;
    end else if (!m_pending) begin
      nx_pending = any;
      nx_pc = mr ? bus.pc_mepc : (any ? {bus.pc_mtvec[63:2], 2'b00} : m_pc);
    end else begin
      nx_pending = !bus.redirect_ready;
      nx_pc = m_pc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_pending = nx_pending;
    m_pc      = nx_pc;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    clr();
    bus.mstatus  = 64'h0;
    bus.mie      = 64'h0;
    bus.pc_mtvec = 64'h8000_0104;
    bus.pc_mepc  = 64'h0;
    @(negedge clk);

    // Reset forces even the combinational pulses low.
    bus.wb_valid = 1; bus.wb_is_ecall = 1;
    eval();
    chk("rst_excep", {62'd0, bus.excep_csr_update}, 64'd0);
    chk("rst_flush", {63'd0, bus.flush}, 64'd0);
    step();
    eval();
    chk("rst_pc", bus.redirect_pc, 64'h0);
    step();
    $display("txn reset: outputs idle");

    rst = 1; clr();
    bus.wb_valid = 1; bus.wb_is_ecall = 1;
    eval();
    chk("ecall_excep", {62'd0, bus.excep_csr_update}, 64'd1);
    chk("ecall_flush", {63'd0, bus.flush}, 64'd1);
    chk("ecall_kill",  {63'd0, bus.wb_kill}, 64'd0);
    step();
    clr();
    eval();
    chk("ecall_rvalid", {63'd0, bus.redirect_valid}, 64'd1);
    chk("ecall_rpc", bus.redirect_pc, 64'h8000_0104);
    chk("ecall_once", {62'd0, bus.excep_csr_update}, 64'd0);
    step();
    eval();
    chk("ecall_hold", bus.redirect_pc, 64'h8000_0104);
    bus.redirect_ready = 1;
    eval();
    step();
    clr();
    eval();
    chk("ecall_done", {63'd0, bus.redirect_valid}, 64'd0);
    step();
    $display("txn ecall: redirect to 0x%0h", m_pc);

    bus.pc_mepc = 64'h8000_0020;
    bus.wb_valid = 1; bus.wb_is_mret = 1;
    eval();
    chk("mret_pulse", {63'd0, bus.mret_csr_update}, 64'd1);
    chk("mret_noexc", {62'd0, bus.excep_csr_update}, 64'd0);
    step();
    clr(); bus.redirect_ready = 1;
    eval();
    chk("mret_rpc", bus.redirect_pc, 64'h8000_0020);
    step();
    $display("txn mret: redirect to 0x%0h", m_pc);

    clr();
    bus.mstatus = 64'h8; bus.mie = 64'h80; bus.pc_mtvec = 64'h8000_0107;
    bus.timer_irq = 1; bus.wb_valid = 1;
    eval();
    chk("irq_excep", {62'd0, bus.excep_csr_update}, 64'd2);
    chk("irq_kill",  {63'd0, bus.wb_kill}, 64'd1);
    step();
    clr(); bus.redirect_ready = 1;
    eval();
    chk("irq_rpc", bus.redirect_pc, 64'h8000_0104);
    step();
    clr();
    bus.mstatus = 64'h0; bus.timer_irq = 1; bus.wb_valid = 1;
    eval();
    chk("irq_masked", {62'd0, bus.excep_csr_update}, 64'd0);
    chk("irq_masked_flush", {63'd0, bus.flush}, 64'd0);
    step();
    $display("txn irq: taken when enabled, ignored when masked");

    bus.mstatus = 64'h8; bus.mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("busy_defer", {62'd0, bus.excep_csr_update}, 64'd0);
      step();
    end
    bus.mem_busy = 0;
    eval();
    chk("busy_release", {62'd0, bus.excep_csr_update}, 64'd2);
    step();
    clr(); bus.redirect_ready = 1;
    eval();
    step();
    $display("txn irq_deferred: taken after mem_busy drops");

    clr();
    bus.wb_valid = 1; bus.wb_is_ecall = 1; bus.timer_irq = 1;
    eval();
    chk("both_excep", {62'd0, bus.excep_csr_update}, 64'd1);
    chk("both_kill",  {63'd0, bus.wb_kill}, 64'd0);
    step();
    bus.wb_is_ecall = 0;
    for (int i = 0; i < 4; i++) begin
      eval();
      chk("both_rvalid", {63'd0, bus.redirect_valid}, 64'd1);
      chk("both_nopulse", {62'd0, bus.excep_csr_update}, 64'd0);
      step();
    end
    bus.redirect_ready = 1;
    eval();
    step();
    bus.redirect_ready = 0;
    eval();
    chk("both_irq_retaken", {62'd0, bus.excep_csr_update}, 64'd2);
    step();
    clr(); bus.redirect_ready = 1;
    eval();
    step();
    $display("txn ecall_vs_irq: ecall first, irq afterwards");

    clr();
    bus.wb_valid = 1; bus.wb_is_ecall = 1;
    eval();
    step();
    clr();
    eval();
    chk("rstmid_pre", {63'd0, bus.redirect_valid}, 64'd1);
    step();
    rst = 0;
    eval();
    chk("rstmid_rvalid0", {63'd0, bus.redirect_valid}, 64'd0);
    step();
    rst = 1;
    eval();
    chk("rstmid_rvalid", {63'd0, bus.redirect_valid}, 64'd0);
    chk("rstmid_flush",  {63'd0, bus.flush}, 64'd0);
    chk("rstmid_pc",     bus.redirect_pc, 64'h0);
    step();
    $display("txn reset_mid_redirect: redirect abandoned");

    for (int i = 0; i < 3000; i++) begin
      logic [63:0] ms, mi;
      rst                = ($urandom_range(0, 63) != 0);
      bus.wb_valid       = ($urandom_range(0, 3) != 0);
      bus.wb_is_ecall    = ($urandom_range(0, 5) == 0);
      bus.wb_is_mret     = ($urandom_range(0, 5) == 0);
      bus.timer_irq      = $urandom_range(0, 1) == 1;
      bus.mem_busy       = ($urandom_range(0, 2) == 0);
      bus.redirect_ready = ($urandom_range(0, 2) != 0);
      ms = {$urandom, $urandom};
      mi = {$urandom, $urandom};
      ms[3] = ($urandom_range(0, 3) != 0);
      mi[7] = ($urandom_range(0, 3) != 0);
      bus.mstatus  = ms;
      bus.mie      = mi;
      bus.pc_mtvec = {$urandom, $urandom};
      bus.pc_mepc  = {$urandom, $urandom};
      eval();
      step();
    end
    $display("txn random: 3000 cycles");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050243_trap_ctrl.md
YSYX_22050243_TRAP_CTRL -- requirements
Module: ysyx_22050243_trap_ctrl

Interface
REQ-001 SHALL have parameter DBUS_DATA_WIDTH, default 64, PC/CSR data width.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on posedge.
REQ-003 SHALL have port rst, input, 1, synchronous, active-low reset.
REQ-004 SHALL have port wb_valid, input, 1, valid instruction present in WB this cycle.
REQ-005 SHALL have port wb_is_ecall, input, 1, WB instruction is ECALL; qualified by wb_valid.
REQ-006 SHALL have port wb_is_mret, input, 1, WB instruction is MRET; qualified by wb_valid.
REQ-007 SHALL have port timer_irq, input, 1, level machine-timer interrupt request.
REQ-008 SHALL have port mem_busy, input, 1, data-bus access outstanding in MEM.
REQ-009 SHALL have port mstatus, input, DBUS_DATA_WIDTH, CSR mstatus value.
REQ-010 SHALL have port mie, input, DBUS_DATA_WIDTH, CSR mie value.
REQ-011 SHALL have port pc_mtvec, input, DBUS_DATA_WIDTH, CSR mtvec value.
REQ-012 SHALL have port pc_mepc, input, DBUS_DATA_WIDTH, CSR mepc value.
REQ-013 SHALL have port redirect_ready, input, 1, IF accepts a redirect this cycle.
REQ-014 SHALL have port excep_csr_update, output, 2, trap pulse to CSR: 01 ECALL, 10 timer interrupt, 00 none.
REQ-015 SHALL have port mret_csr_update, output, 1, MRET pulse to CSR.
REQ-016 SHALL have port wb_kill, output, 1, suppress WB register write and retirement.
REQ-017 SHALL have port flush, output, 1, squash IF/ID, ID/EX and EX/MEM contents.
REQ-018 SHALL have port redirect_valid, output, 1, new fetch PC offered to IF.
REQ-019 SHALL have port redirect_pc, output, DBUS_DATA_WIDTH, new fetch PC.

Function
REQ-020 SHALL implement FSM states IDLE and REDIRECT.
REQ-021 In IDLE, irq_take SHALL equal timer_irq & mstatus[3] & mie[7] & wb_valid & !mem_busy.
REQ-022 In IDLE, events SHALL use priority ECALL (wb_valid & wb_is_ecall) > MRET (wb_valid & wb_is_mret) > irq_take; only one event is taken per cycle.
REQ-023 The taken event SHALL drive excep_csr_update or mret_csr_update combinationally in the same cycle T, high for exactly that one cycle.
REQ-024 In cycle T, flush SHALL be 1, and wb_kill SHALL be 1 only for an interrupt; the state SHALL become REDIRECT at T+1.
REQ-025 On entry to REDIRECT, redirect_pc SHALL register {pc_mtvec[63:2], 2'b00} for ECALL or interrupt, and pc_mepc for MRET, both sampled in cycle T.
REQ-026 In REDIRECT, redirect_valid and flush SHALL be 1, and redirect_pc SHALL be held stable.
REQ-027 REDIRECT SHALL return to IDLE on the cycle where redirect_ready=1 (handshake complete).
REQ-028 In REDIRECT, all event inputs SHALL be ignored, with no pulses; a still-asserted timer_irq SHALL be re-evaluated in IDLE.
REQ-029 When no event is taken in IDLE, all outputs SHALL be 0, and redirect_pc SHALL hold its last value.
REQ-030 When mem_busy=1 with an enabled timer_irq, the interrupt SHALL be deferred, not dropped, while the level persists.
REQ-031 With ECALL and an enabled irq in the same cycle, only ECALL SHALL be taken; the irq is taken after the redirect, once the handler has MIE set.

Reset
REQ-032 When rst=0 at posedge, the state SHALL become IDLE and redirect_pc SHALL become 0.
REQ-033 Reset SHALL force all outputs to 0 while rst=0, including the combinational pulses; reset mid-REDIRECT SHALL abandon the redirect.

Structure
REQ-034 Shared package ysyx_22050243_pkg SHALL hold:
- the state enum
- cause codes EXC_ECALL=2'b01 and EXC_TIMER=2'b10
- bit indices MSTATUS_MIE=3 and MIE_MTIE=7
REQ-035 Event priority selection SHALL live in a combinational sub-module ysyx_22050243_trap_arb.

Verification
REQ-036 Scenario: ECALL at WB, mtvec=0x8000_0104 -> excep=01 for 1 cycle, flush=1; next cycle redirect_valid=1 with redirect_pc=0x8000_0104, held until redirect_ready.
REQ-037 Scenario: MRET at WB, mepc=0x8000_0020 -> mret_csr_update=1 for 1 cycle; then redirect_pc=0x8000_0020.
REQ-038 Scenario: timer_irq=1, mstatus=0x8, mie=0x80, wb_valid=1 -> excep=10 with wb_kill=1, then redirect to mtvec; with mstatus=0 -> no response.
REQ-039 Scenario: enabled irq with mem_busy=1 for 3 cycles -> no pulse for those cycles; pulse on the first cycle mem_busy=0.
REQ-040 Scenario: ECALL with irq in the same cycle -> excep=01 only; redirect_ready held 0 for 4 cycles -> redirect_valid stays 1 and no second pulse.
REQ-041 Scenario: rst=0 while in REDIRECT -> next cycle redirect_valid=0, flush=0, redirect_pc=0.
